// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo.sv
`default_nettype none
// =============================================================================
// ad_ip_jesd204_tpl_dac_dma_fifo : DMA-to-DAC elastic FIFO with prefill/underflow
// Option: AD_TPL_DAC_FIFO_UNF_HOLD_EN repeats the last popped word while starved.
// Revision: 1.0
// =============================================================================
module ad_ip_jesd204_tpl_dac_dma_fifo #(
  parameter int DMA_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH     = 5,
  parameter int START_LEVEL    = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      dma_xfer_req_i,
  input  logic                      dma_valid_i,
  output logic                      dma_ready_o,
  input  logic [DMA_DATA_WIDTH-1:0] dma_data_i,
  input  logic                      dac_valid_i,
  output logic [DMA_DATA_WIDTH-1:0] dac_ddata_o,
  output logic                      dac_dunf_o,
  output logic [ADDR_WIDTH:0]       fifo_level_o
);

  localparam logic [ADDR_WIDTH:0] c_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] c_START = (ADDR_WIDTH+1)'(START_LEVEL);
  localparam logic [ADDR_WIDTH:0] c_ONE   = (ADDR_WIDTH+1)'(1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_PREFILL = 2'd1;
  localparam logic [1:0] c_RUN     = 2'd2;

  logic [DMA_DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  logic [ADDR_WIDTH:0]       wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH:0]       rd_cnt_q, rd_cnt_d;
  logic [1:0]                state_q, state_d;
  logic [DMA_DATA_WIDTH-1:0] ddata_q, ddata_d;
  logic                      dunf_q, dunf_d;
`ifdef AD_TPL_DAC_FIFO_UNF_HOLD_EN
  logic [DMA_DATA_WIDTH-1:0] last_q, last_d;
`endif

  logic [ADDR_WIDTH:0]       w_level;
  logic                      w_ready;
  logic                      w_wr;
  logic                      w_empty;
  logic [DMA_DATA_WIDTH-1:0] w_rd_word;
  logic [DMA_DATA_WIDTH-1:0] w_fill;

  // Counters are one bit wider than the address so full and empty differ.
  assign w_level   = wr_cnt_q - rd_cnt_q;
  assign w_ready   = dma_xfer_req_i & ~reset_i & (w_level != c_DEPTH);
  assign w_wr      = dma_valid_i & w_ready;
  assign w_empty   = (w_level == '0);
  assign w_rd_word = mem_q[rd_cnt_q[ADDR_WIDTH-1:0]];

`ifdef AD_TPL_DAC_FIFO_UNF_HOLD_EN
  assign w_fill = last_q;
`else
  assign w_fill = '0;
`endif

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    state_d  = state_q;
    ddata_d  = ddata_q;
    dunf_d   = 1'b0;
`ifdef AD_TPL_DAC_FIFO_UNF_HOLD_EN
    last_d   = last_q;
`endif
    if (!dma_xfer_req_i) begin
      // Flush: discard pending words silently, no underflow is reported.
      wr_cnt_d = '0;
      rd_cnt_d = '0;
      state_d  = c_IDLE;
      ddata_d  = '0;
`ifdef AD_TPL_DAC_FIFO_UNF_HOLD_EN
      last_d   = '0;
`endif
    end else begin
      if (w_wr) wr_cnt_d = wr_cnt_q + c_ONE;
      case (state_q)
        c_IDLE: state_d = c_PREFILL;
        c_PREFILL: begin
          if (dac_valid_i) ddata_d = w_fill;
          if (w_level >= c_START) state_d = c_RUN;
        end
        c_RUN: begin
          if (dac_valid_i) begin
            if (!w_empty) begin
              ddata_d  = w_rd_word;
              rd_cnt_d = rd_cnt_q + c_ONE;
`ifdef AD_TPL_DAC_FIFO_UNF_HOLD_EN
              last_d   = w_rd_word;
`endif
            end else begin
              // A same-cycle write is not forwarded; the read is starved.
              dunf_d  = 1'b1;
              ddata_d = w_fill;
              state_d = c_PREFILL;
            end
          end
        end
        default: state_d = c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      state_q  <= c_IDLE;
      ddata_q  <= '0;
      dunf_q   <= 1'b0;
`ifdef AD_TPL_DAC_FIFO_UNF_HOLD_EN
      last_q   <= '0;
`endif
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      state_q  <= state_d;
      ddata_q  <= ddata_d;
      dunf_q   <= dunf_d;
`ifdef AD_TPL_DAC_FIFO_UNF_HOLD_EN
      last_q   <= last_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) mem_q[wr_cnt_q[ADDR_WIDTH-1:0]] <= dma_data_i;
  end

  assign dma_ready_o  = w_ready;
  assign dac_ddata_o  = ddata_q;
  assign dac_dunf_o   = dunf_q;
  assign fifo_level_o = w_level;

endmodule
`default_nettype wire

// File: tb/tb_ad_ip_jesd204_tpl_dac_dma_fifo.sv
`default_nettype none
// Bench for ad_ip_jesd204_tpl_dac_dma_fifo: vector table, directed corner cases
// and random traffic, all checked against a queue-based reference model.
module tb_ad_ip_jesd204_tpl_dac_dma_fifo;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int SL    = 16;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          dma_xfer_req;
  logic          dma_valid;
  logic          dma_ready;
  logic [DW-1:0] dma_data;
  logic          dac_valid;
  logic [DW-1:0] dac_ddata;
  logic          dac_dunf;
  logic [AW:0]   fifo_level;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_dma_fifo #(
    .DMA_DATA_WIDTH(DW),
    .ADDR_WIDTH    (AW),
    .START_LEVEL   (SL)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .dma_xfer_req_i(dma_xfer_req),
    .dma_valid_i   (dma_valid),
    .dma_ready_o   (dma_ready),
    .dma_data_i    (dma_data),
    .dac_valid_i   (dac_valid),
    .dac_ddata_o   (dac_ddata),
    .dac_dunf_o    (dac_dunf),
    .fifo_level_o  (fifo_level)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue of stored words plus a coarse phase.
  logic [DW-1:0] m_q [$];
  int            m_phase;    // 0 flushed, 1 prefilling, 2 streaming
  logic [DW-1:0] m_dd;
  logic [DW-1:0] m_last;
  logic          m_unf;
  logic          m_accepted;

  typedef struct {
    logic          xfer;
    logic          v;
    logic [DW-1:0] d;
    logic          dv;
    logic [DW-1:0] e_dd;
    logic          e_unf;
    logic [AW:0]   e_lvl;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_phase = 0;
    m_dd    = '0;
    m_last  = '0;
    m_unf   = 1'b0;
  endtask

  function automatic logic [DW-1:0] fill_word();
`ifdef AD_TPL_DAC_FIFO_UNF_HOLD_EN
    return m_last;
`else
    return '0;
`endif
  endfunction

  task automatic model_step(input logic xfer, input logic v, input logic [DW-1:0] d,
                            input logic dv, input logic rdy);
    int lvl;
    lvl = m_q.size();
    if (!xfer) begin
      model_clear();
    end else begin
      m_unf = 1'b0;
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (dv) m_dd = fill_word();
        if (lvl >= SL) m_phase = 2;
      end else if (dv) begin
        if (lvl > 0) begin
          m_dd   = m_q.pop_front();
          m_last = m_dd;
        end else begin
          m_unf   = 1'b1;
          m_dd    = fill_word();
          m_phase = 1;
        end
      end
      if (v && rdy) m_q.push_back(d);
    end
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic cyc(input logic xfer, input logic v, input logic [DW-1:0] d, input logic dv);
    logic exp_rdy;
    dma_xfer_req = xfer;
    dma_valid    = v;
    dma_data     = d;
    dac_valid    = dv;
    #3;
    exp_rdy = xfer && (m_q.size() != DEPTH);
    chk("dma_ready", {63'd0, dma_ready}, {63'd0, exp_rdy});
    m_accepted = v && exp_rdy;
    model_step(xfer, v, d, dv, exp_rdy);
    @(posedge clk);
    #1;
    chk("dac_ddata", dac_ddata, m_dd);
    chk("dac_dunf", {63'd0, dac_dunf}, {63'd0, m_unf});
    chk("fifo_level", DW'(fifo_level), DW'(m_q.size()));
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int acc;
    int unf_cnt;
    logic [DW-1:0] exp_fill;

    reset        = 1'b1;
    dma_xfer_req = 1'b0;
    dma_valid    = 1'b0;
    dma_data     = '0;
    dac_valid    = 1'b0;
    model_clear();
    m_accepted   = 1'b0;

    for (int i = 0; i < 21; i++) begin
      tbl[i].xfer  = 1'b1;
      tbl[i].e_unf = 1'b0;
      if (i < 16) begin
        tbl[i].v = 1'b1; tbl[i].d = DW'(i + 1); tbl[i].dv = 1'b1;
        tbl[i].e_dd = '0; tbl[i].e_lvl = (AW+1)'(i + 1);
      end else if (i == 16) begin
        tbl[i].v = 1'b0; tbl[i].d = '0; tbl[i].dv = 1'b1;
        tbl[i].e_dd = '0; tbl[i].e_lvl = (AW+1)'(16);
      end else begin
        tbl[i].v = 1'b0; tbl[i].d = '0; tbl[i].dv = 1'b1;
        tbl[i].e_dd = DW'(i - 16); tbl[i].e_lvl = (AW+1)'(32 - i);
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ddata", dac_ddata, '0);
    chk("rst_dunf", {63'd0, dac_dunf}, '0);
    chk("rst_ready", {63'd0, dma_ready}, '0);
    chk("rst_level", DW'(fifo_level), '0);
    reset = 1'b0;

    // Prefill to START_LEVEL then stream out in order.
    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].xfer, tbl[i].v, tbl[i].d, tbl[i].dv);
      chk("tbl_ddata", dac_ddata, tbl[i].e_dd);
      chk("tbl_dunf", {63'd0, dac_dunf}, {63'd0, tbl[i].e_unf});
      chk("tbl_level", DW'(fifo_level), DW'(tbl[i].e_lvl));
    end

    // Full: 40 offered words, exactly 32 accepted.
    cyc(1'b0, 1'b0, '0, 1'b0);
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b1, rnd64(), 1'b0);
      if (m_accepted) acc++;
    end
    chk("t2_accepted", DW'(acc), DW'(32));
    chk("t2_level", DW'(fifo_level), DW'(32));
    chk("t2_ready_full", {63'd0, dma_ready}, '0);

    // Concurrent read/write at level 8.
    for (int i = 0; i < 24; i++) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("t4_level_start", DW'(fifo_level), DW'(8));
    unf_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 1'b1, rnd64(), 1'b1);
      if (dac_dunf) unf_cnt++;
    end
    chk("t4_level_end", DW'(fifo_level), DW'(8));
    chk("t4_no_dunf", DW'(unf_cnt), '0);

    // Underflow after the last word 0xA5.
    cyc(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, (i == 15) ? DW'('hA5) : DW'('h100 + i), 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("t3_level_one", DW'(fifo_level), DW'(1));
    cyc(1'b1, 1'b0, '0, 1'b1);
    chk("t3_last_word", dac_ddata, DW'('hA5));
    cyc(1'b1, 1'b0, '0, 1'b1);
`ifdef AD_TPL_DAC_FIFO_UNF_HOLD_EN
    exp_fill = DW'('hA5);
`else
    exp_fill = '0;
`endif
    chk("t3_dunf", {63'd0, dac_dunf}, DW'(1));
    chk("t3_fill", dac_ddata, exp_fill);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("t3_dunf_pulse", {63'd0, dac_dunf}, '0);
    cyc(1'b1, 1'b1, DW'('h77), 1'b1);
    chk("t3_prefill_no_pop", DW'(fifo_level), DW'(1));
    chk("t3_prefill_fill", dac_ddata, exp_fill);

    // Flush from RUN at level 20.
    for (int i = 0; i < 19; i++) cyc(1'b1, 1'b1, rnd64(), 1'b0);
    cyc(1'b1, 1'b1, rnd64(), 1'b1);
    chk("t5_level_20", DW'(fifo_level), DW'(20));
    chk("t5_popped", dac_ddata, DW'('h77));
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("t5_level", DW'(fifo_level), '0);
    chk("t5_ddata", dac_ddata, '0);
    chk("t5_dunf", {63'd0, dac_dunf}, '0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, rnd64(), 1'b1);
    chk("t5_reprefill", dac_ddata, '0);

    // Asynchronous reset in the middle of streaming.
    for (int i = 0; i < 13; i++) cyc(1'b1, 1'b1, rnd64(), 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_ddata", dac_ddata, '0);
    chk("t6_dunf", {63'd0, dac_dunf}, '0);
    chk("t6_ready", {63'd0, dma_ready}, '0);
    chk("t6_level", DW'(fifo_level), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), rnd64(),
          ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
